// File: rtl/dcache_pkg.sv
// Shared types, widths and address helpers for the L1 data cache.
package dcache_pkg;

  localparam int unsigned LINES     = 16;
  localparam int unsigned BLOCK_W   = 256;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned WORDS     = BLOCK_W / WORD_W;
  localparam int unsigned BYTE_W    = 2;
  localparam int unsigned OFF_W     = $clog2(WORDS);
  localparam int unsigned IDX_W     = $clog2(LINES);
  localparam int unsigned BLK_OFF_W = OFF_W + BYTE_W;
  localparam int unsigned TAG_W     = ADDR_W - IDX_W - BLK_OFF_W;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WB,
    FETCH,
    FILL
  } state_t;

  typedef logic [WORDS-1:0][WORD_W-1:0] block_t;

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [OFF_W-1:0]  off;
    logic [BYTE_W-1:0] bsel;
  } addr_t;

  // Split a CPU byte address into tag / index / word offset / byte select.
  function automatic addr_t split_addr(input logic [ADDR_W-1:0] addr);
    return addr_t'(addr);
  endfunction

  // Block-aligned memory address for a given tag and line index.
  function automatic logic [ADDR_W-1:0] blk_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx);
    return {tag, idx, BLK_OFF_W'(0)};
  endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side signals of the data cache, bundled.
interface dcache_if;
  import dcache_pkg::*;

  logic                 cpu_req_i;
  logic                 cpu_we_i;
  logic [ADDR_W-1:0]    cpu_addr_i;
  logic [WORD_W-1:0]    cpu_data_i;
  logic [WORD_W-1:0]    cpu_data_o;
  logic                 cpu_stall_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [ADDR_W-1:0]    mem_addr_o;
  logic [BLOCK_W-1:0]   mem_data_o;
  logic [BLOCK_W-1:0]   mem_data_i;
  logic                 mem_ack_i;

  // Cache view.
  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    output cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  // CPU pipeline plus off-chip memory view.
  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_data_i, mem_data_i, mem_ack_i,
    input  cpu_data_o, cpu_stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_sram.sv
// Per-line tag/valid/dirty/data storage: async read, sync block fill or word update.
module dcache_sram
  import dcache_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  block_t            fill_data,
  input  logic              word_en,
  input  logic [OFF_W-1:0]  word_off,
  input  logic [WORD_W-1:0] word_data,
  output logic [TAG_W-1:0]  rd_tag_c,
  output logic              rd_valid_c,
  output logic              rd_dirty_c,
  output block_t            rd_data_c
);

  logic [TAG_W-1:0] tag_q [LINES];
  block_t           data_q [LINES];
  logic [LINES-1:0] valid_q;
  logic [LINES-1:0] dirty_q;

  assign rd_tag_c   = tag_q[idx];
  assign rd_valid_c = valid_q[idx];
  assign rd_dirty_c = dirty_q[idx];
  assign rd_data_c  = data_q[idx];

  // Line status: cleared on reset, a fill yields clean-valid, a word write marks dirty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_en) begin
      dirty_q[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid qualifies their contents.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_en) begin
      data_q[idx][word_off] <= word_data;
    end
  end

endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back / write-allocate L1 data cache between MEM stage and memory.
module dcache_controller
  import dcache_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  dcache_if.slave  bus
);

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  block_t            mem_data_q, mem_data_d;
  block_t            fill_q;

  addr_t             cpu_a;
  logic              unused_bsel;
  logic [TAG_W-1:0]  rd_tag;
  logic              rd_valid, rd_dirty;
  block_t            rd_data;
  logic              hit_c, ack_c, lookup_c, word_en, fill_en;

  assign cpu_a       = split_addr(bus.cpu_addr_i);
  assign unused_bsel = ^cpu_a.bsel;

  dcache_sram u_sram (
    .clk        (clk_i),
    .rst_n      (rst_i),
    .idx        (cpu_a.idx),
    .fill_en    (fill_en),
    .fill_tag   (cpu_a.tag),
    .fill_data  (fill_q),
    .word_en    (word_en),
    .word_off   (cpu_a.off),
    .word_data  (bus.cpu_data_i),
    .rd_tag_c   (rd_tag),
    .rd_valid_c (rd_valid),
    .rd_dirty_c (rd_dirty),
    .rd_data_c  (rd_data)
  );

  // Lookup only counts in IDLE; an ack only counts while a request is outstanding.
  assign lookup_c = (state_q == IDLE);
  assign hit_c    = bus.cpu_req_i && rd_valid && (rd_tag == cpu_a.tag);
  assign ack_c    = mem_req_q && bus.mem_ack_i;
  assign word_en  = rst_i && lookup_c && hit_c && bus.cpu_we_i;
  assign fill_en  = rst_i && (state_q == FILL);

  assign bus.cpu_data_o  = (lookup_c && hit_c && !bus.cpu_we_i) ? rd_data[cpu_a.off] : '0;
  assign bus.cpu_stall_o = !lookup_c || (bus.cpu_req_i && !hit_c);
  assign bus.mem_req_o   = mem_req_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_data_o  = mem_data_q;

  // State and registered memory-side outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Capture the fetched block; it is written into the arrays during FILL.
  always_ff @(posedge clk_i) begin
    if (state_q == FETCH && ack_c) begin
      fill_q <= block_t'(bus.mem_data_i);
    end
  end

  // Next state and next memory request; request drops on every accepted ack.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = '0;
    mem_data_d = '0;

    unique case (state_q)
      IDLE:    if (bus.cpu_req_i && !hit_c) state_d = MISS;
      MISS:    state_d = (rd_valid && rd_dirty) ? WB : FETCH;
      WB:      if (ack_c) state_d = FETCH;
      FETCH:   if (ack_c) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    mem_req_d = ((state_d == WB) || (state_d == FETCH)) && !ack_c;
    if (state_d == WB) begin
      mem_we_d   = 1'b1;
      mem_addr_d = blk_addr(rd_tag, cpu_a.idx);
      mem_data_d = rd_data;
    end else if (state_d == FETCH) begin
      mem_addr_d = blk_addr(cpu_a.tag, cpu_a.idx);
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Self-checking bench for dcache_controller with a 10-cycle memory model.
module tb_dcache_controller;

  localparam int LAT        = 10;
  localparam int CLEAN_MISS = 3 + LAT;          // detect + MISS + fetch wait + FILL
  localparam int DIRTY_MISS = CLEAN_MISS + LAT + 1; // write-back wait + one request-free cycle

  typedef struct {
    logic [31:0]  addr;
    logic         we;
    logic [255:0] data;
  } mreq_t;

  logic clk = 1'b0;
  logic rst_n;
  dcache_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  mreq_t got_q[$];
  mreq_t exp_q[$];
  logic [255:0] resp_mem [logic [31:0]];
  logic [255:0] ref_mem  [logic [31:0]];
  logic spur_ack = 1'b0;
  int   cnt = 0;
  mreq_t resp_r;

  // Reference cache state.
  bit           m_valid [16];
  bit           m_dirty [16];
  logic [22:0]  m_tag   [16];
  logic [255:0] m_line  [16];

  function automatic logic [255:0] dflt(input logic [31:0] ba);
    logic [255:0] b;
    for (int w = 0; w < 8; w++) b[w*32 +: 32] = ba + 32'(w) * 32'h0101_0101 + 32'h0BAD_0000;
    return b;
  endfunction

  function automatic logic [255:0] resp_rd(input logic [31:0] ba);
    if (resp_mem.exists(ba)) return resp_mem[ba];
    return dflt(ba);
  endfunction

  function automatic logic [255:0] ref_rd(input logic [31:0] ba);
    if (ref_mem.exists(ba)) return ref_mem[ba];
    return dflt(ba);
  endfunction

  // Off-chip memory: acks in the LAT-th cycle of each request, logs every request.
  always @(negedge clk) begin
    bus.mem_ack_i = 1'b0;
    if (!rst_n) begin
      cnt = 0;
    end else if (bus.mem_req_o) begin
      cnt++;
      if (cnt == 1) begin
        resp_r.addr = bus.mem_addr_o;
        resp_r.we   = bus.mem_we_o;
        resp_r.data = bus.mem_we_o ? bus.mem_data_o : '0;
        got_q.push_back(resp_r);
      end
      if (cnt == LAT) begin
        bus.mem_ack_i = 1'b1;
        cnt = 0;
        if (bus.mem_we_o) resp_mem[bus.mem_addr_o] = bus.mem_data_o;
        else bus.mem_data_i = resp_rd(bus.mem_addr_o);
      end
    end else begin
      cnt = 0;
    end
    if (spur_ack) bus.mem_ack_i = 1'b1;
  end

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
  endfunction

  // Predict stall length, load data and memory traffic for one access.
  task automatic model_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                              output int exp_stall, output logic [31:0] exp_rd);
    int idx, off;
    logic [22:0] tag;
    logic [31:0] ba;
    mreq_t r;
    idx = int'(addr[8:5]);
    off = int'(addr[4:2]);
    tag = addr[31:9];
    exp_q.delete();
    exp_stall = 0;
    if (!(m_valid[idx] && m_tag[idx] == tag)) begin
      exp_stall = CLEAN_MISS;
      if (m_valid[idx] && m_dirty[idx]) begin
        ba = {m_tag[idx], addr[8:5], 5'b0};
        r.addr = ba; r.we = 1'b1; r.data = m_line[idx];
        exp_q.push_back(r);
        ref_mem[ba] = m_line[idx];
        exp_stall = DIRTY_MISS;
      end
      ba = {tag, addr[8:5], 5'b0};
      r.addr = ba; r.we = 1'b0; r.data = '0;
      exp_q.push_back(r);
      m_line[idx]  = ref_rd(ba);
      m_tag[idx]   = tag;
      m_valid[idx] = 1'b1;
      m_dirty[idx] = 1'b0;
    end
    if (we) begin
      m_line[idx][off*32 +: 32] = wd;
      m_dirty[idx] = 1'b1;
      exp_rd = '0;
    end else begin
      exp_rd = m_line[idx][off*32 +: 32];
    end
  endtask

  // Present one access and hold it until the stall clears (bounded).
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           output int stall, output logic [31:0] rd);
    got_q.delete();
    @(negedge clk);
    bus.cpu_req_i  = 1'b1;
    bus.cpu_we_i   = we;
    bus.cpu_addr_i = addr;
    bus.cpu_data_i = wd;
    #1;
    stall = 0;
    while (bus.cpu_stall_o && stall <= 100) begin
      stall++;
      @(negedge clk);
      #1;
    end
    rd = bus.cpu_data_o;
  endtask

  task automatic go_idle();
    @(negedge clk);
    bus.cpu_req_i = 1'b0;
    bus.cpu_we_i  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.cpu_req_i = 1'b0; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = '0; bus.cpu_data_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    n_checks++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL reset_stall got %b exp 0", bus.cpu_stall_o); else n_pass++;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL reset_req got %b exp 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.mem_we_o !== 1'b0) $display("FAIL reset_we got %b exp 0", bus.mem_we_o); else n_pass++;
    n_checks++; if (bus.mem_addr_o !== 32'h0) $display("FAIL reset_addr got %h exp 0", bus.mem_addr_o); else n_pass++;
    n_checks++; if (bus.mem_data_o !== 256'h0) $display("FAIL reset_mdata got %h exp 0", bus.mem_data_o); else n_pass++;
    n_checks++; if (bus.cpu_data_o !== 32'h0) $display("FAIL reset_cdata got %h exp 0", bus.cpu_data_o); else n_pass++;
    rst_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    n_checks++;
    if (bus.cpu_stall_o !== 1'b0 || bus.mem_req_o !== 1'b0)
      $display("FAIL idle_quiet got stall=%b req=%b exp 0 0", bus.cpu_stall_o, bus.mem_req_o);
    else n_pass++;
  endtask

  // A list of accesses, each checked for stall length, load data and memory traffic.
  task automatic run_list(input string nm, input logic we_l[], input logic [31:0] ad_l[],
                          input logic [31:0] wd_l[], output int st_l[], output logic [31:0] rd_l[]);
    int st, es;
    logic [31:0] rd, er;
    st_l = new[ad_l.size()];
    rd_l = new[ad_l.size()];
    for (int k = 0; k < ad_l.size(); k++) begin
      do_access(we_l[k], ad_l[k], wd_l[k], st, rd);
      model_access(we_l[k], ad_l[k], wd_l[k], es, er);
      st_l[k] = st; rd_l[k] = rd;
      n_checks++; if (st !== es) $display("FAIL %s%0d_stall got %0d exp %0d", nm, k, st, es); else n_pass++;
      n_checks++; if (rd !== er) $display("FAIL %s%0d_data got %h exp %h", nm, k, rd, er); else n_pass++;
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL %s%0d_nreq got %0d exp %0d", nm, k, got_q.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
        n_checks++;
        if (got_q[i].addr !== exp_q[i].addr || got_q[i].we !== exp_q[i].we || got_q[i].data !== exp_q[i].data)
          $display("FAIL %s%0d_req%0d got addr=%h we=%b data=%h exp addr=%h we=%b data=%h", nm, k, i,
                   got_q[i].addr, got_q[i].we, got_q[i].data, exp_q[i].addr, exp_q[i].we, exp_q[i].data);
        else n_pass++;
      end
      if (st > 100) return;
    end
  endtask

  task automatic test_read_miss();
    int st[]; logic [31:0] rd[];
    logic [255:0] b;
    b = dflt(32'h0);
    b[63:32] = 32'hDEAD_BEEF;
    resp_mem[32'h0] = b;
    ref_mem[32'h0]  = b;
    run_list("rmiss", '{1'b0}, '{32'h0000_0004}, '{32'h0}, st, rd);
    n_checks++; if (st[0] !== 13) $display("FAIL rmiss_cycles got %0d exp 13", st[0]); else n_pass++;
    n_checks++; if (rd[0] !== 32'hDEAD_BEEF) $display("FAIL rmiss_word got %h exp deadbeef", rd[0]); else n_pass++;
  endtask

  task automatic test_read_hit();
    int st[]; logic [31:0] rd[];
    run_list("rhit", '{1'b0}, '{32'h0000_0008}, '{32'h0}, st, rd);
  endtask

  task automatic test_write_hit();
    int st[]; logic [31:0] rd[];
    run_list("whit", '{1'b1, 1'b0}, '{32'h0000_0004, 32'h0000_0004}, '{32'h1234_5678, 32'h0}, st, rd);
    n_checks++; if (rd[1] !== 32'h1234_5678) $display("FAIL whit_readback got %h exp 12345678", rd[1]); else n_pass++;
  endtask

  task automatic test_dirty_evict();
    int st[]; logic [31:0] rd[];
    run_list("evict", '{1'b0}, '{32'h0000_0204}, '{32'h0}, st, rd);
    n_checks++; if (st[0] !== 24) $display("FAIL evict_cycles got %0d exp 24", st[0]); else n_pass++;
  endtask

  task automatic test_write_miss();
    int st[]; logic [31:0] rd[];
    run_list("wmiss", '{1'b1, 1'b0, 1'b0}, '{32'h0000_0420, 32'h0000_0420, 32'h0000_0020},
             '{32'hA5A5_A5A5, 32'h0, 32'h0}, st, rd);
    n_checks++; if (rd[1] !== 32'hA5A5_A5A5) $display("FAIL wmiss_word0 got %h exp a5a5a5a5", rd[1]); else n_pass++;
    n_checks++; if (st[2] !== DIRTY_MISS) $display("FAIL wmiss_dirty got %0d exp %0d", st[2], DIRTY_MISS); else n_pass++;
  endtask

  task automatic test_spurious_ack();
    int st[]; logic [31:0] rd[];
    go_idle();
    @(posedge clk); spur_ack = 1'b1;
    @(posedge clk); spur_ack = 1'b0;
    @(negedge clk); #1;
    n_checks++;
    if (bus.mem_req_o !== 1'b0 || bus.cpu_stall_o !== 1'b0)
      $display("FAIL spur_ack got req=%b stall=%b exp 0 0", bus.mem_req_o, bus.cpu_stall_o);
    else n_pass++;
    run_list("spur", '{1'b0}, '{32'h0000_0024}, '{32'h0}, st, rd);
  endtask

  task automatic test_reset_mid();
    int st[]; logic [31:0] rd[];
    int k;
    run_list("rmid", '{1'b1}, '{32'h0000_0204}, '{32'hCAFE_F00D}, st, rd);
    @(negedge clk);
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0004;
    #1;
    k = 0;
    while (!(bus.mem_req_o && bus.mem_we_o) && k < 50) begin
      @(negedge clk); #1; k++;
    end
    n_checks++; if (k >= 50) $display("FAIL rmid_wb_seen got timeout exp write-back request"); else n_pass++;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    bus.cpu_req_i = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (bus.mem_req_o !== 1'b0) $display("FAIL rmid_req got %b exp 0", bus.mem_req_o); else n_pass++;
    n_checks++; if (bus.cpu_stall_o !== 1'b0) $display("FAIL rmid_stall got %b exp 0", bus.cpu_stall_o); else n_pass++;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_list("rmid_after", '{1'b0}, '{32'h0000_0004}, '{32'h0}, st, rd);
    n_checks++; if (st[0] !== 13) $display("FAIL rmid_miss got %0d exp 13", st[0]); else n_pass++;
  endtask

  task automatic test_random();
    logic we_l[];
    logic [31:0] ad_l[], wd_l[];
    int st[]; logic [31:0] rd[];
    we_l = new[40]; ad_l = new[40]; wd_l = new[40];
    for (int k = 0; k < 40; k++) begin
      we_l[k] = 1'($urandom_range(0, 1));
      ad_l[k] = (32'($urandom_range(0, 2)) << 9) | (32'($urandom_range(0, 3)) << 5) |
                (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      wd_l[k] = $urandom;
    end
    run_list("rand", we_l, ad_l, wd_l, st, rd);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_read_miss();
    test_read_hit();
    test_write_hit();
    test_dirty_evict();
    test_write_miss();
    test_spurious_ack();
    test_reset_mid();
    test_random();
    go_idle();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
